// File: rtl/fish_btn_if.sv
// rtl/fish_btn_if.sv - push-button bundle between board pins and the button conditioner
// Signals:
//   btn_raw  : raw asynchronous button pins, bit order {BtnD, BtnL, BtnR, BtnU, BtnC}
//   btn_db   : debounced level per button
//   btn_scen : one-cycle pulse per accepted press
//   btn_mcen : press pulse plus auto-repeat pulses while held
// Modports: master drives btn_raw and observes the conditioned outputs; slave is the conditioner.
interface fish_btn_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_scen;
    logic [N_BTN-1:0] btn_mcen;

    modport master (
        output btn_raw,
        input  btn_db,
        input  btn_scen,
        input  btn_mcen
    );

    modport slave (
        input  btn_raw,
        output btn_db,
        output btn_scen,
        output btn_mcen
    );
endinterface

// File: rtl/fish_btn_conditioner.sv
// rtl/fish_btn_conditioner.sv - synchronize, debounce and edge-condition the board push-buttons
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   btn   : fish_btn_if.slave (btn_raw in; btn_db, btn_scen, btn_mcen out, all registered)
// Macro FISH_BTN_REPEAT_EN: when defined, HELD buttons emit auto-repeat pulses on btn_mcen;
// when undefined, btn_mcen carries only the press pulse (identical to btn_scen).
module fish_btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    fish_btn_if.slave  btn
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef FISH_BTN_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCHK = 2'd1,
        HELD = 2'd2,
        RCHK = 2'd3
    } state_t;

    logic [N_BTN-1:0] meta_q;
    logic [N_BTN-1:0] sync_q;

    state_t           state_q [N_BTN];
    logic [CW-1:0]    cnt_q   [N_BTN];
    logic [N_BTN-1:0] db_q;
    logic [N_BTN-1:0] scen_q;
    logic [N_BTN-1:0] mcen_q;
`ifdef FISH_BTN_REPEAT_EN
    // Set once the first (REPEAT_DELAY) repeat has fired; later repeats use REPEAT_PERIOD.
    logic [N_BTN-1:0] rep_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn.btn_raw;
            sync_q <= meta_q;
        end
    end

    // One FSM per button; the shared counter is the debounce counter in PCHK/RCHK
    // and the repeat counter in HELD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            db_q   <= '0;
            scen_q <= '0;
            mcen_q <= '0;
`ifdef FISH_BTN_REPEAT_EN
            rep_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                scen_q[i] <= 1'b0;
                mcen_q[i] <= 1'b0;
                case (state_q[i])
                    IDLE: begin
                        db_q[i]  <= 1'b0;
                        cnt_q[i] <= '0;
                        if (sync_q[i]) begin
                            state_q[i] <= PCHK;
                            cnt_q[i]   <= CNT_ONE;
                        end
                    end
                    PCHK: begin
                        if (!sync_q[i]) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == DB_LAST) begin
                            state_q[i] <= HELD;
                            db_q[i]    <= 1'b1;
                            scen_q[i]  <= 1'b1;
                            mcen_q[i]  <= 1'b1;
                            cnt_q[i]   <= '0;
`ifdef FISH_BTN_REPEAT_EN
                            rep_q[i]   <= 1'b0;
`endif
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                    HELD: begin
                        db_q[i] <= 1'b1;
                        if (!sync_q[i]) begin
                            state_q[i] <= RCHK;
                            cnt_q[i]   <= CNT_ONE;
                        end
`ifdef FISH_BTN_REPEAT_EN
                        else if (cnt_q[i] == (rep_q[i] ? PER_LAST : DLY_LAST)) begin
                            mcen_q[i] <= 1'b1;
                            rep_q[i]  <= 1'b1;
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
`endif
                    end
                    RCHK: begin
                        // Level stays high until the release is proven stable.
                        if (sync_q[i]) begin
                            state_q[i] <= HELD;
                            cnt_q[i]   <= '0;
`ifdef FISH_BTN_REPEAT_EN
                            rep_q[i]   <= 1'b0;
`endif
                        end else if (cnt_q[i] == DB_LAST) begin
                            state_q[i] <= IDLE;
                            db_q[i]    <= 1'b0;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                        db_q[i]    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign btn.btn_db   = db_q;
    assign btn.btn_scen = scen_q;
    assign btn.btn_mcen = mcen_q;

endmodule

// File: tb/tb_fish_btn_conditioner.sv
// tb/tb_fish_btn_conditioner.sv - directed self-checking bench for fish_btn_conditioner
module tb_fish_btn_conditioner;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [4:0] exp_m;

    fish_btn_if #(.N_BTN(5)) bif ();

    fish_btn_conditioner #(
        .N_BTN(5),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(bif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset with every button held: outputs must stay 0 during reset.
        bif.btn_raw = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_db_%0d", i), bif.btn_db, 5'b0);
            chk($sformatf("rst_scen_%0d", i), bif.btn_scen, 5'b0);
            chk($sformatf("rst_mcen_%0d", i), bif.btn_mcen, 5'b0);
        end
        rst_n = 1'b1;
        // Edge i=0 is the first released edge; press accepted after edge 5.
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rel_scen_%0d", i), bif.btn_scen, (i == 5) ? 5'b11111 : 5'b0);
            chk($sformatf("rel_mcen_%0d", i), bif.btn_mcen, (i == 5) ? 5'b11111 : 5'b0);
            chk($sformatf("rel_db_%0d", i), bif.btn_db, (i >= 5) ? 5'b11111 : 5'b0);
        end

        // Reset asserted mid-HELD clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midheld_rst_db", bif.btn_db, 5'b0);
        bif.btn_raw = 5'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("postrst_scen_%0d", i), bif.btn_scen, 5'b0);
            chk($sformatf("postrst_db_%0d", i), bif.btn_db, 5'b0);
        end

        // Clean press of BtnU: raw high for edges 0..39, low from edge 40.
        bif.btn_raw = 5'b00010;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 39) bif.btn_raw = 5'b0;
            exp_m = (i == 5) ? 5'b00010 : 5'b0;
`ifdef FISH_BTN_REPEAT_EN
            if (i >= 13 && i <= 41 && ((i - 13) % 3) == 0) exp_m = 5'b00010;
`endif
            chk($sformatf("press_scen_%0d", i), bif.btn_scen, (i == 5) ? 5'b00010 : 5'b0);
            chk($sformatf("press_mcen_%0d", i), bif.btn_mcen, exp_m);
            chk($sformatf("press_db_%0d", i), bif.btn_db, (i >= 5 && i < 45) ? 5'b00010 : 5'b0);
        end

        // Glitch on BtnC: 3 high, 1 low, 3 high never reaches 4 stable samples.
        for (int i = 0; i < 16; i++) begin
            bif.btn_raw = ((i < 3) || (i >= 4 && i < 7)) ? 5'b00001 : 5'b0;
            tick();
            chk($sformatf("glitch_db_%0d", i), bif.btn_db, 5'b0);
            chk($sformatf("glitch_scen_%0d", i), bif.btn_scen, 5'b0);
            chk($sformatf("glitch_mcen_%0d", i), bif.btn_mcen, 5'b0);
        end

        // Release bounce on BtnD: raw low before edges 7 and 8, high again from edge 9.
        // FSM re-enters HELD at edge 11 with the repeat counter at 0, so repeats at 19, 22.
        bif.btn_raw = 5'b10000;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 6) bif.btn_raw = 5'b0;
            if (i == 8) bif.btn_raw = 5'b10000;
            exp_m = (i == 5) ? 5'b10000 : 5'b0;
`ifdef FISH_BTN_REPEAT_EN
            if (i == 19 || i == 22) exp_m = 5'b10000;
`endif
            chk($sformatf("bounce_scen_%0d", i), bif.btn_scen, (i == 5) ? 5'b10000 : 5'b0);
            chk($sformatf("bounce_mcen_%0d", i), bif.btn_mcen, exp_m);
            chk($sformatf("bounce_db_%0d", i), bif.btn_db, (i >= 5) ? 5'b10000 : 5'b0);
        end
        bif.btn_raw = 5'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("bounce_release_db", bif.btn_db, 5'b0);

        // Simultaneous press of BtnR and BtnL.
        bif.btn_raw = 5'b01100;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("simul_scen_%0d", i), bif.btn_scen, (i == 5) ? 5'b01100 : 5'b0);
            chk($sformatf("simul_mcen_%0d", i), bif.btn_mcen, (i == 5) ? 5'b01100 : 5'b0);
            chk($sformatf("simul_db_%0d", i), bif.btn_db, (i >= 5) ? 5'b01100 : 5'b0);
        end
        bif.btn_raw = 5'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("simul_release_db", bif.btn_db, 5'b0);

        // Reset asserted mid-PCHK on BtnC: no pulse leaks out.
        bif.btn_raw = 5'b00001;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        bif.btn_raw = 5'b0;
        #1;
        chk("midpchk_rst_scen", bif.btn_scen, 5'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("midpchk_scen_%0d", i), bif.btn_scen, 5'b0);
            chk($sformatf("midpchk_db_%0d", i), bif.btn_db, 5'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
